// File: rtl/aes_decryption_iter_pkg.sv
// rtl/aes_decryption_iter_pkg.sv - shared AES types, inverse S-box and GF(2^8) helpers for the decryption core
package aes_decryption_iter_pkg;

    localparam int AES_ROUNDS      = 14;
    localparam int AES_BLOCK_BITS  = 128;
    localparam int AES_STATE_BYTES = 16;

    // Expanded key schedule, entry 0 is the first key applied by the encryptor
    typedef logic [AES_ROUNDS:0][AES_BLOCK_BITS-1:0] round_keys_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        OUT   = 2'd2
    } fsm_state_t;

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Byte i of a block is row i%4, column i/4; byte 0 sits in the top bits
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < AES_STATE_BYTES; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_decryption_iter_round.sv
// rtl/aes_decryption_iter_round.sv - combinational single inverse AES round (decryption_aes_round)
module decryption_aes_round
    import aes_decryption_iter_pkg::*;
(
    input  logic [AES_BLOCK_BITS-1:0] state_in,
    input  logic [AES_BLOCK_BITS-1:0] round_key,
    input  logic                      inv_mix_en,
    output logic [AES_BLOCK_BITS-1:0] state_out
);

    logic [AES_BLOCK_BITS-1:0] keyed;

    // Key is added before InvMixColumns so the encryption-order schedule is usable unmodified
    assign keyed     = inv_sub_bytes(inv_shift_rows(state_in)) ^ round_key;
    assign state_out = inv_mix_en ? inv_mix_columns(keyed) : keyed;

endmodule

// File: rtl/aes_decryption_iter.sv
// rtl/aes_decryption_iter.sv - iterative AES-256 decryptor, one round per clock; AES_DECRYPTION_KEY_LATCH_EN snapshots the key schedule on accept
module aes_decryption_iter
    import aes_decryption_iter_pkg::*;
#(
    parameter int ROUND_NUMBER = 14,
    parameter int TDATA_WIDTH  = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [TDATA_WIDTH-1:0] aes_in_tdata,
    input  logic                   aes_in_tvalid,
    input  logic                   aes_in_tlast,
    output logic                   aes_in_tready,
    input  round_keys_t            round_keys,
    input  logic                   round_keys_valid,
    output logic [TDATA_WIDTH-1:0] aes_out_tdata,
    output logic                   aes_out_tvalid,
    output logic                   aes_out_tlast,
    input  logic                   aes_out_tready
);

    localparam int RW = $clog2(ROUND_NUMBER + 1);

    fsm_state_t             fsm_q;
    fsm_state_t             fsm_d;
    logic [TDATA_WIDTH-1:0] state_q;
    logic [RW-1:0]          rnd_q;
    logic                   last_q;
    logic                   accept;
    logic [TDATA_WIDTH-1:0] round_key;
    logic [TDATA_WIDTH-1:0] round_out;

    assign accept = aes_in_tvalid & aes_in_tready;

`ifdef AES_DECRYPTION_KEY_LATCH_EN
    round_keys_t keys_q;

    // Private copy of the schedule so the key source may move on after accept
    always_ff @(posedge clk) begin
        if (reset) keys_q <= '0;
        else if (accept) keys_q <= round_keys;
    end

    assign round_key = keys_q[rnd_q];
`else
    assign round_key = round_keys[rnd_q];
`endif

    decryption_aes_round u_round (
        .state_in   (state_q),
        .round_key  (round_key),
        .inv_mix_en (rnd_q != '0),
        .state_out  (round_out)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) fsm_q <= IDLE;
        else       fsm_q <= fsm_d;
    end

    // Next state: an accept from OUT restarts rounds in the same cycle as the output handshake
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (accept) fsm_d = ROUND;
            ROUND:   if (rnd_q == '0) fsm_d = OUT;
            OUT:     if (accept) fsm_d = ROUND;
                     else if (aes_out_tready) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Handshake outputs; data is only exposed while the result is valid
    always_comb begin
        aes_in_tready  = ~reset & round_keys_valid &
                         ((fsm_q == IDLE) | ((fsm_q == OUT) & aes_out_tready));
        aes_out_tvalid = (fsm_q == OUT);
        aes_out_tdata  = (fsm_q == OUT) ? state_q : '0;
        aes_out_tlast  = (fsm_q == OUT) & last_q;
    end

    // Datapath: initial whitening with the last key, then one inverse round per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
            rnd_q   <= '0;
            last_q  <= 1'b0;
        end else if (accept) begin
            state_q <= aes_in_tdata ^ round_keys[ROUND_NUMBER];
            rnd_q   <= RW'(ROUND_NUMBER - 1);
            last_q  <= aes_in_tlast;
        end else if (fsm_q == ROUND) begin
            state_q <= round_out;
            if (rnd_q != '0) rnd_q <= rnd_q - RW'(1);
        end
    end

endmodule

// File: tb/tb_aes_decryption_iter.sv
// tb/tb_aes_decryption_iter.sv - directed and randomized bench for aes_decryption_iter against an AES-256 encryption model
module tb_aes_decryption_iter;
    import aes_decryption_iter_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] in_tdata = '0;
    logic         in_tvalid = 1'b0;
    logic         in_tlast = 1'b0;
    logic         in_tready;
    round_keys_t  keys = '0;
    logic         rkv = 1'b0;
    logic [127:0] out_tdata;
    logic         out_tvalid;
    logic         out_tlast;
    logic         out_tready = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rk_model [15];

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_decryption_iter dut (
        .clk              (clk),
        .reset            (reset),
        .aes_in_tdata     (in_tdata),
        .aes_in_tvalid    (in_tvalid),
        .aes_in_tlast     (in_tlast),
        .aes_in_tready    (in_tready),
        .round_keys       (keys),
        .round_keys_valid (rkv),
        .aes_out_tdata    (out_tdata),
        .aes_out_tvalid   (out_tvalid),
        .aes_out_tlast    (out_tlast),
        .aes_out_tready   (out_tready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = m_mul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) begin
            rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            keys[r]     = rk_model[r];
        end
    endtask

    // Forward cipher on a 16-byte array (index = row + 4*column)
    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ rk_model[0][127-8*i -: 8];
        for (int rnd = 1; rnd <= 14; rnd++) begin
            for (int i = 0; i < 16; i++) st[i] = sbox[st[i]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) tmp[r+4*c] = st[r+4*((c+r)%4)];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 14) begin
                    st[4*c]   = m_mul(tmp[4*c], 8'h02) ^ m_mul(tmp[4*c+1], 8'h03) ^ tmp[4*c+2] ^ tmp[4*c+3];
                    st[4*c+1] = tmp[4*c] ^ m_mul(tmp[4*c+1], 8'h02) ^ m_mul(tmp[4*c+2], 8'h03) ^ tmp[4*c+3];
                    st[4*c+2] = tmp[4*c] ^ tmp[4*c+1] ^ m_mul(tmp[4*c+2], 8'h02) ^ m_mul(tmp[4*c+3], 8'h03);
                    st[4*c+3] = m_mul(tmp[4*c], 8'h03) ^ tmp[4*c+1] ^ tmp[4*c+2] ^ m_mul(tmp[4*c+3], 8'h02);
                end else begin
                    for (int r = 0; r < 4; r++) st[r+4*c] = tmp[r+4*c];
                end
            end
            for (int i = 0; i < 16; i++) st[i] ^= rk_model[rnd][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present one block, wait for it to be taken, and count cycles to output valid
    task automatic run_block(input logic [127:0] ct, input logic last, output int lat);
        int guard = 0;
        in_tdata  = ct;
        in_tlast  = last;
        in_tvalid = 1'b1;
        while (!in_tready && guard < 50) begin
            tick();
            guard++;
        end
        check("accept_wait", 128'(guard < 50), 128'(1));
        tick();
        in_tvalid = 1'b0;
        lat = 0;
        while (!out_tvalid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int           lat, cyc, idx, got, last_acc;
        logic         acc, hs, flag, l0;
        logic [127:0] pt, ct, d0;
        logic [127:0] pts [8];
        logic [127:0] cts [8];
        logic [127:0] exp_q [$];
        logic         expl_q [$];

        build_sbox();
        expand_key(C3_KEY);
        check("model_c3", encrypt(C3_PT), C3_CT);

        // Reset state
        rkv = 1'b1;
        tick();
        tick();
        check("rst_in_tready", 128'(in_tready), 128'(0));
        check("rst_out_tvalid", 128'(out_tvalid), 128'(0));
        check("rst_out_tdata", out_tdata, 128'(0));
        check("rst_out_tlast", 128'(out_tlast), 128'(0));
        reset = 1'b0;
        #1;
        check("post_rst_in_tready", 128'(in_tready), 128'(1));
        tick();

        // FIPS-197 C.3 known answer
        out_tready = 1'b1;
        run_block(C3_CT, 1'b1, lat);
        check("kat_latency", 128'(lat), 128'(14));
        check("kat_tdata", out_tdata, C3_PT);
        check("kat_tlast", 128'(out_tlast), 128'(1));
        tick();
        check("kat_single_beat", 128'(out_tvalid), 128'(0));

        // Backpressure with a random key
        expand_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        pt = rand128();
        ct = encrypt(pt);
        out_tready = 1'b0;
        run_block(ct, 1'b0, lat);
        check("bp_latency", 128'(lat), 128'(14));
        d0 = out_tdata;
        l0 = out_tlast;
        flag = 1'b1;
        in_tdata  = rand128();
        in_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_tdata !== d0 || out_tlast !== l0 || out_tvalid !== 1'b1 || in_tready !== 1'b0) flag = 1'b0;
        end
        check("bp_stable", 128'(flag), 128'(1));
        check("bp_tdata", d0, pt);
        check("bp_tlast", 128'(l0), 128'(0));
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
        tick();
        check("bp_single_beat", 128'(out_tvalid), 128'(0));

        // Back-to-back stream of 8 random blocks
        for (int i = 0; i < 8; i++) begin
            pts[i] = rand128();
            cts[i] = encrypt(pts[i]);
        end
        idx = 0; got = 0; cyc = 0; last_acc = 0;
        in_tdata  = cts[0];
        in_tlast  = 1'b0;
        in_tvalid = 1'b1;
        while (got < 8 && cyc < 400) begin
            acc = in_tvalid && in_tready;
            hs  = out_tvalid && out_tready;
            if (hs) begin
                check("b2b_tdata", out_tdata, exp_q.pop_front());
                check("b2b_tlast", 128'(out_tlast), 128'(expl_q.pop_front()));
                got++;
            end
            if (acc) begin
                if (idx > 0) begin
                    check("b2b_overlap", 128'(hs), 128'(1));
                    check("b2b_interval", 128'(cyc - last_acc), 128'(15));
                end
                last_acc = cyc;
                exp_q.push_back(pts[idx]);
                expl_q.push_back(in_tlast);
            end
            tick();
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 8) begin
                    in_tdata = cts[idx];
                    in_tlast = idx[0];
                end else begin
                    in_tvalid = 1'b0;
                end
            end
        end
        check("b2b_count", 128'(got), 128'(8));

        // Keys not valid: no accept; then drop validity mid-round
        pt = rand128();
        ct = encrypt(pt);
        rkv = 1'b0;
        in_tdata  = ct;
        in_tlast  = 1'b1;
        in_tvalid = 1'b1;
        flag = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (in_tready !== 1'b0 || out_tvalid !== 1'b0) flag = 1'b0;
        end
        check("rkv_low_no_accept", 128'(flag), 128'(1));
        rkv = 1'b1;
        #1;
        check("rkv_high_ready", 128'(in_tready), 128'(1));
        tick();
        in_tvalid = 1'b0;
        lat = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            lat++;
        end
        rkv = 1'b0;
        while (!out_tvalid && lat < 40) begin
            tick();
            lat++;
        end
        check("rkv_drop_latency", 128'(lat), 128'(14));
        check("rkv_drop_tdata", out_tdata, pt);
        check("rkv_drop_tlast", 128'(out_tlast), 128'(1));
        tick();
        check("rkv_drop_single_beat", 128'(out_tvalid), 128'(0));
        rkv = 1'b1;

        // Reset at round 7 discards the block
        pt = rand128();
        in_tdata  = encrypt(pt);
        in_tvalid = 1'b1;
        tick();
        in_tvalid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst_mid_tvalid", 128'(out_tvalid), 128'(0));
        check("rst_mid_idle_ready", 128'(in_tready), 128'(1));
        flag = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_tvalid !== 1'b0) flag = 1'b0;
        end
        check("rst_mid_no_beat", 128'(flag), 128'(1));
        pt = rand128();
        run_block(encrypt(pt), 1'b0, lat);
        check("rst_after_latency", 128'(lat), 128'(14));
        check("rst_after_tdata", out_tdata, pt);
        tick();

`ifdef AES_DECRYPTION_KEY_LATCH_EN
        // Keys zeroed one cycle after accept
        expand_key(C3_KEY);
        in_tdata  = C3_CT;
        in_tlast  = 1'b0;
        in_tvalid = 1'b1;
        tick();
        in_tvalid = 1'b0;
        tick();
        keys = '0;
        lat = 1;
        while (!out_tvalid && lat < 40) begin
            tick();
            lat++;
        end
        check("latch_latency", 128'(lat), 128'(14));
        check("latch_tdata", out_tdata, C3_PT);
        tick();
        expand_key(C3_KEY);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
